fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Program-counter / fetch-address stage that consumes the branch unit's resolved outcome
//  (shouldBranch, direction, 16-bit offset, flushBack) and drives the instruction-fetch address.
//  Sequential increment on each accepted fetch; relative redirect on a taken branch.
//  Fixed-length bubble (flush window) after every redirect so wrong-path fetches never issue.
// PARAMETERS
//  ADDR_W        16      PC / offset width
//  RESET_VECTOR  16'h0   PC value loaded on reset
//  PC_INCR       1       PC step per accepted fetch
//  FLUSH_CYCLES  2       bubble cycles after a redirect (legal range 1..7)
// PORTS
//  clock_i            in   1       single clock, rising edge
//  reset_i            in   1       synchronous, active-high
//  enable_i           in   1       run enable; low = hold PC, no fetch
//  shouldBranch_i     in   1       taken-branch strobe from branch unit
//  branchDirection_i  in   1       1 = forward (+offset), 0 = backward (-offset)
//  branchOffset_i     in   ADDR_W  unsigned branch magnitude
//  branchPc_i         in   ADDR_W  PC of the resolving branch instruction
//  flushBack_i        in   1       branch unit flush request
//  fetchReady_i       in   1       instruction memory accepts this cycle
//  fetchValid_o       out  1       fetchAddr_o is a valid request
//  fetchAddr_o        out  ADDR_W  instruction fetch address
//  pc_o               out  ADDR_W  architectural PC (next to fetch)
//  flushBack_o        out  1       flush fetch/decode latches (high during flush window)
//  wrapFault_o        out  1       only with PC_WRAP_TRAP_EN (else tied 0)
// BEHAVIOUR
//  Reset (synchronous): state=IDLE, pc=RESET_VECTOR, fetchValid_o=0, fetchAddr_o=RESET_VECTOR,
//   flushBack_o=0, wrapFault_o=0, flush counter=0. Reset mid-flush/mid-request aborts everything.
//  States: IDLE -> RUN when enable_i=1. RUN -> IDLE when enable_i=0 and no request outstanding.
//   RUN/IDLE -> FLUSH on redirect. FLUSH -> RUN after FLUSH_CYCLES cycles (IDLE if enable_i=0).
//   HALT only with PC_WRAP_TRAP_EN; exit only by reset.
//  Redirect = shouldBranch_i & flushBack_i, sampled in any state except HALT.
//   target = branchDir ? branchPc_i + branchOffset_i : branchPc_i - branchOffset_i, modulo 2^ADDR_W.
//   Next cycle: pc=target, flushBack_o=1, fetchValid_o=0, counter=FLUSH_CYCLES-1.
//  RUN: fetchValid_o=1, fetchAddr_o=pc. Handshake fetchValid_o & fetchReady_i -> pc += PC_INCR
//   (wraps 16'hFFFF -> 16'h0000 silently). Valid & !ready: addr/valid held stable, pc held.
//  Simultaneous redirect + accepted fetch: redirect wins; the accepted fetch is wrong-path,
//   covered by flushBack_o.
//  Redirect during FLUSH: newest target wins, counter restarts at FLUSH_CYCLES-1.
//  shouldBranch_i without flushBack_i, or flushBack_i alone: ignored (no redirect).
//  Latency: redirect sampled at edge N -> first target fetch valid at edge N+1+FLUSH_CYCLES.
//  enable_i=0 while valid & !ready: request held until accepted, then IDLE.
// CONFIGURATION
//  PC_WRAP_TRAP_EN defined: target adder carry (forward) or borrow (backward) -> no redirect,
//   state=HALT, wrapFault_o=1 (sticky), fetchValid_o=0, flushBack_o=1 for one cycle.
//   Sequential increment wrap also traps.
//  PC_WRAP_TRAP_EN undefined: all arithmetic wraps modulo 2^ADDR_W; wrapFault_o tied 0; no HALT.
// STRUCTURE
//  Shared package pa_core_pkg: fetch-state encoding (IDLE/RUN/FLUSH/HALT), ADDR_W, RESET_VECTOR,
//   branch-direction constants (DIR_FWD=1, DIR_BWD=0).
//  One sub-module: pc_target_calc (combinational add/sub of branchPc_i/offset, outputs target + wrap).
//  Top holds FSM, PC register, flush counter, fetch handshake.
// TESTING
//  1 Reset, enable_i=1, fetchReady_i=1 -> fetchAddr_o 0,1,2,3 on consecutive cycles.
//  2 fetchReady_i low 3 cycles at addr 5 -> fetchAddr_o stays 5, fetchValid_o=1, pc_o=5 throughout.
//  3 Branch fwd, branchPc_i=10, offset=6 -> flushBack_o=1 for 2 cycles, then fetchAddr_o=16.
//  4 Branch bwd, branchPc_i=4, offset=8 -> no trap: target 16'hFFFC;
//    trap: wrapFault_o=1, fetchValid_o=0 until reset.
//  5 Second redirect (target 40) during flush of first (target 20) -> first fetch after flush is 40.
//  6 reset_i pulsed mid-flush -> next cycle all outputs at reset values, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/pa_core_pkg.sv
// Shared core package: fetch-state encoding, address width, reset vector,
// PC step, flush length and branch-direction constants.
package pa_core_pkg;

    localparam int          ADDR_W       = 16;
    localparam logic [15:0] RESET_VECTOR = 16'h0000;
    localparam int          PC_INCR      = 1;
    localparam int          FLUSH_CYCLES = 2;
    localparam int          FLUSH_CNT_W  = 3;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_BWD = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Branch target adder: base +/- offset modulo 2^W, with carry/borrow flag.
// Ports: base, offset, direction (DIR_FWD adds) -> target, wrap.
module pc_target_calc
    import pa_core_pkg::*;
#(
    parameter int W = pa_core_pkg::ADDR_W
) (
    input  logic [W-1:0] base,
    input  logic [W-1:0] offset,
    input  logic         direction,
    output logic [W-1:0] target,
    output logic         wrap
);

    logic [W:0] sum;

    // The extra top bit is the carry on add and the borrow on subtract.
    always_comb begin
        if (direction == DIR_FWD) begin
            sum = {1'b0, base} + {1'b0, offset};
        end else begin
            sum = {1'b0, base} - {1'b0, offset};
        end
    end

    assign target = sum[W-1:0];
    assign wrap   = sum[W];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC stage: sequential fetch, relative redirects, fixed flush bubble.
// Ports: clock_i, reset_i (sync, high), enable_i, branch outcome inputs
// (shouldBranch_i, branchDirection_i, branchOffset_i, branchPc_i,
// flushBack_i), fetchReady_i -> fetchValid_o, fetchAddr_o, pc_o,
// flushBack_o, wrapFault_o. Define PC_WRAP_TRAP_EN to halt on PC wrap.
module fetch_pc_unit #(
    parameter int                         ADDR_W       = pa_core_pkg::ADDR_W,
    parameter logic [pa_core_pkg::ADDR_W-1:0] RESET_VECTOR = pa_core_pkg::RESET_VECTOR,
    parameter int                         PC_INCR      = pa_core_pkg::PC_INCR,
    parameter int                         FLUSH_CYCLES = pa_core_pkg::FLUSH_CYCLES
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              shouldBranch_i,
    input  logic              branchDirection_i,
    input  logic [ADDR_W-1:0] branchOffset_i,
    input  logic [ADDR_W-1:0] branchPc_i,
    input  logic              flushBack_i,
    input  logic              fetchReady_i,
    output logic              fetchValid_o,
    output logic [ADDR_W-1:0] fetchAddr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              flushBack_o,
    output logic              wrapFault_o
);

    import pa_core_pkg::*;

    fetch_state_e           state, state_nx;
    logic [ADDR_W-1:0]      pc, pc_nx;
    logic [FLUSH_CNT_W-1:0] cnt, cnt_nx;
    logic                   fault, fault_nx;
    logic                   hflush, hflush_nx;

    logic              redirect;
    logic              accept;
    logic [ADDR_W-1:0] target;
    logic              tgt_wrap;
    logic [ADDR_W:0]   incr;

    pc_target_calc #(.W(ADDR_W)) u_calc (
        .base      (branchPc_i),
        .offset    (branchOffset_i),
        .direction (branchDirection_i),
        .target    (target),
        .wrap      (tgt_wrap)
    );

    assign redirect = shouldBranch_i & flushBack_i;
    assign accept   = (state == ST_RUN) & fetchReady_i;
    assign incr     = {1'b0, pc} + {1'b0, ADDR_W'(PC_INCR)};

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        cnt_nx    = cnt;
        fault_nx  = fault;
        hflush_nx = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (enable_i) state_nx = ST_RUN;
            end
            ST_RUN: begin
                // A stalled request keeps RUN even if enable drops.
                if (accept) begin
                    pc_nx = incr[ADDR_W-1:0];
                    if (!enable_i) state_nx = ST_IDLE;
`ifdef PC_WRAP_TRAP_EN
                    if (incr[ADDR_W]) begin
                        pc_nx     = pc;
                        state_nx  = ST_HALT;
                        fault_nx  = 1'b1;
                        hflush_nx = 1'b1;
                    end
`endif
                end
            end
            ST_FLUSH: begin
                if (cnt == '0) begin
                    state_nx = enable_i ? ST_RUN : ST_IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ST_HALT: begin
            end
        endcase
        // Redirect overrides everything, including a same-cycle accept.
        if (redirect && state != ST_HALT) begin
            state_nx = ST_FLUSH;
            pc_nx    = target;
            cnt_nx   = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
`ifdef PC_WRAP_TRAP_EN
            if (tgt_wrap) begin
                state_nx  = ST_HALT;
                pc_nx     = pc;
                cnt_nx    = cnt;
                fault_nx  = 1'b1;
                hflush_nx = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state  <= ST_IDLE;
            pc     <= RESET_VECTOR;
            cnt    <= '0;
            fault  <= 1'b0;
            hflush <= 1'b0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            cnt    <= cnt_nx;
            fault  <= fault_nx;
            hflush <= hflush_nx;
        end
    end

    assign fetchValid_o = (state == ST_RUN);
    assign fetchAddr_o  = pc;
    assign pc_o         = pc;
    assign flushBack_o  = (state == ST_FLUSH) | hflush;

`ifdef PC_WRAP_TRAP_EN
    assign wrapFault_o = fault;
`else
    logic unused_wrap;
    assign unused_wrap = tgt_wrap ^ incr[ADDR_W] ^ fault;
    assign wrapFault_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random traffic
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_pc_unit;

    localparam int FC = 2;
`ifdef PC_WRAP_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, sb = 1'b0, dir = 1'b0, fb = 1'b0, rdy = 1'b0;
    logic [15:0] off = '0, bpc = '0;
    logic        fetchValid_o, flushBack_o, wrapFault_o;
    logic [15:0] fetchAddr_o, pc_o;

    int checks = 0;
    int errors = 0;

    int m_pc = 0;
    int m_flush = 0;
    bit m_run = 0, m_halt = 0, m_fault = 0, m_hp = 0;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clock_i           (clk),
        .reset_i           (rst),
        .enable_i          (en),
        .shouldBranch_i    (sb),
        .branchDirection_i (dir),
        .branchOffset_i    (off),
        .branchPc_i        (bpc),
        .flushBack_i       (fb),
        .fetchReady_i      (rdy),
        .fetchValid_o      (fetchValid_o),
        .fetchAddr_o       (fetchAddr_o),
        .pc_o              (pc_o),
        .flushBack_o       (flushBack_o),
        .wrapFault_o       (wrapFault_o)
    );

    wire [34:0] act = {fetchValid_o, fetchAddr_o, pc_o, flushBack_o, wrapFault_o};

    function automatic logic [34:0] expv();
        logic [15:0] a;
        logic        v;
        logic        f;
        a = m_pc[15:0];
        v = !m_halt && m_run && m_flush == 0;
        f = m_halt ? m_hp : (m_flush > 0);
        return {v, a, a, f, m_fault};
    endfunction

    task automatic model_update();
        bit acc;
        int t;
        if (rst) begin
            m_pc = 0; m_run = 0; m_halt = 0;
            m_fault = 0; m_hp = 0; m_flush = 0;
            return;
        end
        if (m_halt) begin
            m_hp = 0;
            return;
        end
        acc  = m_run && m_flush == 0 && rdy;
        m_hp = 0;
        if (sb && fb) begin
            t = dir ? int'(bpc) + int'(off) : int'(bpc) - int'(off);
            if (TRAP && (t < 0 || t > 65535)) begin
                m_halt = 1; m_fault = 1; m_hp = 1;
            end else begin
                m_pc = t & 32'hFFFF;
                m_flush = FC;
            end
        end else if (m_flush > 0) begin
            m_flush--;
            if (m_flush == 0) m_run = en;
        end else if (acc) begin
            if (TRAP && m_pc == 65535) begin
                m_halt = 1; m_fault = 1; m_hp = 1;
            end else begin
                m_pc = (m_pc + 1) % 65536;
                m_run = en;
            end
        end else if (en) begin
            m_run = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; sb = 0; fb = 0;
        step();
        rst = 0;
    endtask

    task automatic redirect(input logic d, input logic [15:0] p,
                            input logic [15:0] o);
        sb = 1; fb = 1; dir = d; bpc = p; off = o;
        step();
        sb = 0; fb = 0;
    endtask

    task automatic test_reset();
        en = 1; rdy = 1; sb = 1; fb = 1; bpc = 16'h1234; off = 16'h0042;
        rst = 1;
        step();
        checks++;
        if (act !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", act);
        end
        step();
        checks++;
        if (act !== expv() || fetchAddr_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", act, expv());
        end
        rst = 0; sb = 0; fb = 0;
    endtask

    task automatic test_sequential();
        do_reset();
        en = 1; rdy = 1;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fetchAddr_o !== 16'(i) || fetchValid_o !== 1'b1) begin
                errors++;
                $display("FAIL seq_addr%0d: addr=%h valid=%b want addr=%h valid=1",
                         i, fetchAddr_o, fetchValid_o, 16'(i));
            end
            step();
        end
    endtask

    task automatic test_stall();
        step();
        rdy = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fetchAddr_o !== 16'd5 || fetchValid_o !== 1'b1 || pc_o !== 16'd5) begin
                errors++;
                $display("FAIL stall%0d: addr=%h valid=%b pc=%h want 5/1/5",
                         i, fetchAddr_o, fetchValid_o, pc_o);
            end
            if (i < 3) step();
        end
        rdy = 1;
    endtask

    task automatic test_ignored();
        sb = 1; fb = 0; bpc = 16'h0100; off = 16'h0010; dir = 1;
        step();
        checks++;
        if (flushBack_o !== 1'b0 || act !== expv()) begin
            errors++;
            $display("FAIL ignore_sb_only: got %h want %h", act, expv());
        end
        sb = 0; fb = 1;
        step();
        checks++;
        if (flushBack_o !== 1'b0 || fetchValid_o !== 1'b1 || act !== expv()) begin
            errors++;
            $display("FAIL ignore_fb_only: got %h want %h", act, expv());
        end
        fb = 0;
    endtask

    task automatic test_branch_fwd();
        redirect(1'b1, 16'd10, 16'd6);
        for (int i = 0; i < FC; i++) begin
            checks++;
            if (flushBack_o !== 1'b1 || fetchValid_o !== 1'b0) begin
                errors++;
                $display("FAIL fwd_flush%0d: flush=%b valid=%b want flush=1 valid=0",
                         i, flushBack_o, fetchValid_o);
            end
            step();
        end
        checks++;
        if (fetchAddr_o !== 16'd16 || fetchValid_o !== 1'b1 || flushBack_o !== 1'b0) begin
            errors++;
            $display("FAIL fwd_target: addr=%h valid=%b flush=%b want 0010/1/0",
                     fetchAddr_o, fetchValid_o, flushBack_o);
        end
    endtask

    task automatic test_branch_bwd();
        logic [15:0] e;
        redirect(1'b0, 16'd4, 16'd8);
        if (TRAP) begin
            checks++;
            if (wrapFault_o !== 1'b1 || fetchValid_o !== 1'b0 || flushBack_o !== 1'b1) begin
                errors++;
                $display("FAIL trap_entry: fault=%b valid=%b flush=%b want 1/0/1",
                         wrapFault_o, fetchValid_o, flushBack_o);
            end
            for (int i = 0; i < 3; i++) begin
                step();
                checks++;
                if (wrapFault_o !== 1'b1 || fetchValid_o !== 1'b0 || flushBack_o !== 1'b0) begin
                    errors++;
                    $display("FAIL trap_hold%0d: fault=%b valid=%b flush=%b want 1/0/0",
                             i, wrapFault_o, fetchValid_o, flushBack_o);
                end
            end
            do_reset();
        end else begin
            step();
            step();
            e = 16'hFFFC;
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (fetchAddr_o !== e || fetchValid_o !== 1'b1 || wrapFault_o !== 1'b0) begin
                    errors++;
                    $display("FAIL bwd_wrap%0d: addr=%h valid=%b fault=%b want %h/1/0",
                             i, fetchAddr_o, fetchValid_o, wrapFault_o, e);
                end
                e = e + 16'd1;
                step();
            end
        end
    endtask

    task automatic test_double_redirect();
        do_reset();
        en = 1; rdy = 1;
        step();
        redirect(1'b1, 16'd15, 16'd5);
        redirect(1'b0, 16'd50, 16'd10);
        for (int i = 0; i < FC; i++) begin
            checks++;
            if (flushBack_o !== 1'b1 || fetchValid_o !== 1'b0 || pc_o !== 16'd40) begin
                errors++;
                $display("FAIL dbl_flush%0d: flush=%b valid=%b pc=%h want 1/0/0028",
                         i, flushBack_o, fetchValid_o, pc_o);
            end
            step();
        end
        checks++;
        if (fetchAddr_o !== 16'd40 || fetchValid_o !== 1'b1) begin
            errors++;
            $display("FAIL dbl_target: addr=%h valid=%b want 0028/1",
                     fetchAddr_o, fetchValid_o);
        end
    endtask

    task automatic test_reset_mid_flush();
        en = 1; rdy = 1;
        redirect(1'b1, 16'h0200, 16'h0033);
        rst = 1;
        step();
        checks++;
        if (act !== 35'd0) begin
            errors++;
            $display("FAIL rst_mid_flush: got %h want 0", act);
        end
        rst = 0;
        step();
        checks++;
        if (fetchAddr_o !== 16'd0 || fetchValid_o !== 1'b1 || flushBack_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart: addr=%h valid=%b flush=%b want 0000/1/0",
                     fetchAddr_o, fetchValid_o, flushBack_o);
        end
        step();
        checks++;
        if (fetchAddr_o !== 16'd1) begin
            errors++;
            $display("FAIL rst_restart_next: addr=%h want 0001", fetchAddr_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            en  = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            sb  = ($urandom_range(0, 5) == 0);
            fb  = ($urandom_range(0, 1) == 1);
            dir = ($urandom_range(0, 1) == 1);
            bpc = 16'($urandom);
            off = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                              : 16'($urandom_range(0, 64));
            step();
            checks++;
            if (act !== expv()) begin
                errors++;
                $display("FAIL random%0d: got %h want %h", i, act, expv());
            end
        end
        rst = 0; sb = 0; fb = 0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_ignored();
        test_branch_fwd();
        test_branch_bwd();
        test_double_redirect();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
